// File: rtl/avmm_req_packetizer.sv
// Avalon-MM command packetizer: header + write payload serialised onto an OUT_W-bit valid/ready stream.
// Optional trailer parity beat when PKT_PARITY_EN is defined.
module avmm_req_packetizer #(
  parameter int ADDR_W    = 24,
  parameter int BCNT_W    = 5,
  parameter int OUT_W     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic [BCNT_W-1:0] avs_burstcount,
  output logic              avs_waitrequest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              err
);

  localparam int HDR_W     = 2 + ADDR_W + BCNT_W;
  localparam int HDR_BEATS = (HDR_W + OUT_W - 1) / OUT_W;
  localparam int HDR_BITS  = HDR_BEATS * OUT_W;
  localparam int SLICES    = 32 / OUT_W;
  localparam int BC_W      = $clog2(HDR_BEATS + 1);
  localparam int SC_W      = $clog2(SLICES + 1);

`ifdef PKT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    FETCH
`ifdef PKT_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t              state_reg;
  logic [HDR_BITS-1:0] hdr_sr_reg;
  logic [31:0]         word_buf_reg;
  logic [BC_W-1:0]     beat_cnt_reg;
  logic [SC_W-1:0]     slice_cnt_reg;
  logic [BCNT_W-1:0]   words_left_reg;
  logic                is_write_reg;
  logic [OUT_W-1:0]    par_acc_reg;

  logic [BCNT_W-1:0]   bc_eff;
  logic [BCNT_W-1:0]   bc_clamped;
  logic                bc_over;
  logic                is_burst;
  logic [BCNT_W-1:0]   field;
  logic [HDR_BITS-1:0] hdr_new;
  logic [HDR_BITS-1:0] hdr_shift;
  logic [31:0]         word_shift;
  logic                beat_take;

  // Header assembly from the live command; burstcount 0 means a single word.
  always_comb begin
    bc_eff     = (avs_burstcount == '0) ? BCNT_W'(1) : avs_burstcount;
    bc_over    = avs_burstcount > BCNT_W'(MAX_BURST);
    bc_clamped = bc_over ? BCNT_W'(MAX_BURST) : bc_eff;
    is_burst   = bc_clamped > BCNT_W'(1);
    field      = is_burst ? bc_clamped : BCNT_W'(avs_byteenable);
    hdr_new    = '0;
    hdr_new[0] = avs_write;
    hdr_new[1] = is_burst;
    hdr_new[ADDR_W+1:2] = avs_address;
    hdr_new[ADDR_W+2 +: BCNT_W] = field;
  end

  assign hdr_shift  = hdr_sr_reg >> OUT_W;
  assign word_shift = word_buf_reg >> OUT_W;
  assign beat_take  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_last        <= 1'b0;
      err             <= 1'b0;
      avs_waitrequest <= 1'b1;
      hdr_sr_reg      <= '0;
      word_buf_reg    <= '0;
      beat_cnt_reg    <= '0;
      slice_cnt_reg   <= '0;
      words_left_reg  <= '0;
      is_write_reg    <= 1'b0;
      par_acc_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Waitrequest is still high for the first cycle after reset; only accept once it is low.
          avs_waitrequest <= 1'b0;
          par_acc_reg     <= '0;
          if (!avs_waitrequest && (avs_read || avs_write)) begin
            if ((avs_read && avs_write) || bc_over) err <= 1'b1;
            is_write_reg    <= avs_write;
            hdr_sr_reg      <= hdr_new;
            word_buf_reg    <= avs_writedata;
            words_left_reg  <= avs_write ? bc_clamped : '0;
            beat_cnt_reg    <= '0;
            slice_cnt_reg   <= '0;
            out_valid       <= 1'b1;
            out_data        <= hdr_new[OUT_W-1:0];
            out_last        <= (HDR_BEATS == 1) && !avs_write && !PAR_EN;
            avs_waitrequest <= 1'b1;
            state_reg       <= HDR;
          end
        end

        HDR: begin
          if (beat_take) begin
            par_acc_reg <= par_acc_reg ^ out_data;
            if (beat_cnt_reg == BC_W'(HDR_BEATS - 1)) begin
              if (is_write_reg) begin
                out_data  <= word_buf_reg[OUT_W-1:0];
                out_last  <= (SLICES == 1) && (words_left_reg == BCNT_W'(1)) && !PAR_EN;
                state_reg <= DATA;
              end else begin
`ifdef PKT_PARITY_EN
                out_data  <= par_acc_reg ^ out_data;
                out_last  <= 1'b1;
                state_reg <= PAR;
`else
                out_valid       <= 1'b0;
                out_data        <= '0;
                out_last        <= 1'b0;
                avs_waitrequest <= 1'b0;
                state_reg       <= IDLE;
`endif
              end
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
              hdr_sr_reg   <= hdr_shift;
              out_data     <= hdr_shift[OUT_W-1:0];
              out_last     <= (BC_W'(beat_cnt_reg + 1'b1) == BC_W'(HDR_BEATS - 1))
                              && !is_write_reg && !PAR_EN;
            end
          end
        end

        DATA: begin
          if (beat_take) begin
            par_acc_reg <= par_acc_reg ^ out_data;
            if (slice_cnt_reg == SC_W'(SLICES - 1)) begin
              slice_cnt_reg  <= '0;
              words_left_reg <= words_left_reg - 1'b1;
              if (words_left_reg != BCNT_W'(1)) begin
                out_valid       <= 1'b0;
                out_data        <= '0;
                out_last        <= 1'b0;
                avs_waitrequest <= 1'b0;
                state_reg       <= FETCH;
              end else begin
`ifdef PKT_PARITY_EN
                out_data  <= par_acc_reg ^ out_data;
                out_last  <= 1'b1;
                state_reg <= PAR;
`else
                out_valid       <= 1'b0;
                out_data        <= '0;
                out_last        <= 1'b0;
                avs_waitrequest <= 1'b0;
                state_reg       <= IDLE;
`endif
              end
            end else begin
              slice_cnt_reg <= slice_cnt_reg + 1'b1;
              word_buf_reg  <= word_shift;
              out_data      <= word_shift[OUT_W-1:0];
              out_last      <= (SC_W'(slice_cnt_reg + 1'b1) == SC_W'(SLICES - 1))
                               && (words_left_reg == BCNT_W'(1)) && !PAR_EN;
            end
          end
        end

        FETCH: begin
          // A read here is a protocol violation: flag it and keep waiting for write data.
          if (avs_read) err <= 1'b1;
          if (avs_write) begin
            word_buf_reg    <= avs_writedata;
            out_valid       <= 1'b1;
            out_data        <= avs_writedata[OUT_W-1:0];
            out_last        <= (SLICES == 1) && (words_left_reg == BCNT_W'(1)) && !PAR_EN;
            avs_waitrequest <= 1'b1;
            state_reg       <= DATA;
          end
        end

`ifdef PKT_PARITY_EN
        PAR: begin
          if (beat_take) begin
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_last        <= 1'b0;
            par_acc_reg     <= '0;
            avs_waitrequest <= 1'b0;
            state_reg       <= IDLE;
          end
        end
`endif

        default: begin
          out_valid       <= 1'b0;
          out_last        <= 1'b0;
          avs_waitrequest <= 1'b0;
          state_reg       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_req_packetizer.sv
// Randomized scoreboard bench for avmm_req_packetizer; expected beats come from an arithmetic packet model.
module tb_avmm_req_packetizer;
  localparam int ADDR_W    = 24;
  localparam int BCNT_W    = 5;
  localparam int OUT_W     = 8;
  localparam int MAX_BURST = 16;
  localparam int HDR_BEATS = (2 + ADDR_W + BCNT_W + OUT_W - 1) / OUT_W;
  localparam int SLICES    = 32 / OUT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [3:0]        avs_byteenable = '0;
  logic [BCNT_W-1:0] avs_burstcount = '0;
  logic              avs_waitrequest;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              err;

  avmm_req_packetizer #(
    .ADDR_W(ADDR_W), .BCNT_W(BCNT_W), .OUT_W(OUT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    bit               l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] wq[$];
  int          checks = 0;
  int          errors = 0;
  bit          ready_rand = 1'b0;
  bit          exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_bc(input int bc);
    int e;
    e = (bc == 0) ? 1 : bc;
    if (e > MAX_BURST) e = MAX_BURST;
    return e;
  endfunction

  // Packet model: header word by arithmetic, then bytes LSB-first, then payload, optional XOR trailer.
  task automatic push_expect(input bit wr, input int addr, input int be, input int bc);
    longint hdr;
    int     n;
    int     burst;
    int     fld;
    beat_t  b;
    logic [OUT_W-1:0] x;
    n     = eff_bc(bc);
    burst = (n > 1) ? 1 : 0;
    fld   = burst ? n : be;
    hdr   = longint'(wr) + longint'(burst) * 2 + longint'(addr) * 4
            + longint'(fld) * (longint'(1) << (ADDR_W + 2));
    x = '0;
    for (int i = 0; i < HDR_BEATS; i++) begin
      b.d = OUT_W'((hdr >> (i * OUT_W)) & ((longint'(1) << OUT_W) - 1));
      b.l = 1'b0;
      x   = x ^ b.d;
      exp_q.push_back(b);
    end
    if (wr) begin
      for (int w = 0; w < n; w++) begin
        for (int s = 0; s < SLICES; s++) begin
          b.d = OUT_W'(wq[w] >> (s * OUT_W));
          b.l = 1'b0;
          x   = x ^ b.d;
          exp_q.push_back(b);
        end
      end
    end
`ifdef PKT_PARITY_EN
    b.d = x;
    b.l = 1'b0;
    exp_q.push_back(b);
`endif
    exp_q[exp_q.size() - 1].l = 1'b1;
  endtask

  // Hold the current command until the DUT takes it (waitrequest low at a rising edge).
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (!avs_waitrequest) ok = 1'b1;
    end
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got waitrequest=1 expected 0 within 400 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_wait", avs_waitrequest, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One Avalon command; words come from wq. abort_after>0 resets the DUT after that many words.
  task automatic do_cmd(input bit rd, input bit wr, input int addr, input int be, input int bc,
                        input int abort_after);
    int n;
    n = wr ? eff_bc(bc) : 0;
    while (wq.size() < n) wq.push_back($urandom);
    if ((rd && wr) || bc > MAX_BURST) exp_err = 1'b1;
    push_expect(wr, addr, be, bc);
    $display("cmd rd=%0d wr=%0d addr=0x%06h be=0x%0h bc=%0d words=%0d", rd, wr, addr, be, bc, n);
    avs_address    = ADDR_W'(addr);
    avs_byteenable = 4'(be);
    avs_burstcount = BCNT_W'(bc);
    avs_read       = rd;
    avs_write      = wr;
    avs_writedata  = (n > 0) ? wq[0] : 32'h0;
    wait_accept("cmd");
    chk("latency_valid", out_valid, 1'b1);
    chk("latency_wait", avs_waitrequest, 1'b1);
    avs_read = 1'b0;
    for (int k = 1; k < n; k++) begin
      if (k == abort_after) begin
        avs_write = 1'b0;
        reset_dut();
        wq.delete();
        return;
      end
      avs_writedata = wq[k];
      wait_accept("word");
    end
    avs_write = 1'b0;
    wq.delete();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("err_flag", err, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop and compare on every accepted beat; check hold during stalls.
  initial begin
    bit               stalled;
    logic [OUT_W-1:0] sd;
    logic             sl;
    beat_t            e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, sd);
          chk("stall_last", out_last, sl);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_last", out_last, e.l);
          end
        end
        stalled = out_valid && !out_ready;
        sd = out_data;
        sl = out_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_waitreq", avs_waitrequest, 1'b1);
    rst = 1'b0;

    do_cmd(1, 0, 32'h123456, 4'b0011, 1, 0);
    drain();
    wq.push_back(32'hDEADBEEF);
    do_cmd(0, 1, 0, 4'b1111, 1, 0);
    drain();

    for (int p = 0; p < 2; p++) begin
      ready_rand = (p == 1);
      for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
      do_cmd(0, 1, 32'h10, 4'b1111, 4, 0);
      do_cmd(1, 0, 32'h10, 4'b1111, 8, 0);
      drain();
    end

    ready_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      do_cmd(!wr, wr, int'($urandom_range(0, (1 << ADDR_W) - 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, MAX_BURST)), 0);
    end
    drain();

    ready_rand = 1'b0;
    for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
    do_cmd(0, 1, 32'h10, 4'b1111, 4, 2);
    do_cmd(1, 0, 32'h123456, 4'b0011, 1, 0);
    drain();

    ready_rand = 1'b1;
    do_cmd(0, 1, 32'h000ABC, 4'b1111, 20, 0);
    drain();

    reset_dut();
    chk("err_cleared", err, 1'b0);
    do_cmd(1, 1, 32'h00F00D, 4'b0101, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avmm_req_packetizer.md
Name: avmm_req_packetizer

Overview:
Synthesizable request-side front end of the AVMM-LVDS bridge. It accepts Avalon-MM read/write commands, including bursts, from the local master. Each command is packed into a request header followed by its 32-bit write payload, and the packet is serialised onto an OUT_W-bit valid/ready stream that feeds the LVDS lane serialiser. Address width, burst-count width, lane width and maximum burst are all parameters.

Parameters:
ADDR_W, 24, word address width carried in the header
BCNT_W, 5, burstcount/byteenable field width (must be >= 4)
OUT_W, 8, output beat width; must be 8, 16 or 32
MAX_BURST, 16, largest legal burstcount

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
avs_address  in  ADDR_W  command word address
avs_read  in  1  read command
avs_write  in  1  write command / write data beat
avs_writedata  in  32  write data
avs_byteenable  in  4  byte enables; used for single transfers only
avs_burstcount  in  BCNT_W  burst length; 0 is treated as 1
avs_waitrequest  out  1  stall to master
out_valid  out  1  stream beat valid
out_ready  in  1  stream beat accepted
out_data  out  OUT_W  stream beat
out_last  out  1  last beat of packet
err  out  1  sticky protocol error

Behaviour:
- Reset: rst is asynchronous and active-high. While rst=1: out_valid=0, out_data=0, out_last=0, err=0, avs_waitrequest=1, FSM=IDLE.
- Header packing (HDR_W = 2+ADDR_W+BCNT_W, zero-padded to HDR_BEATS*OUT_W):
  - bit0 = tr (READ=0, WRITE=1)
  - bit1 = burst (1 iff effective burstcount > 1)
  - [ADDR_W+1:2] = address
  - next BCNT_W bits = burstcount if burst, else {0, byteenable}
- Emission order: header LSB-first in OUT_W slices, then each payload word LSB-first in 32/OUT_W slices.
- avs_waitrequest=0 only in IDLE and FETCH; 1 in all other states.
- FSM states: IDLE, HDR, DATA, FETCH, PAR (PAR exists only with the optional feature).
- IDLE: on avs_read|avs_write, capture the command into the header shift register. For a write, also capture avs_writedata into the word buffer. Set remaining words = effective burstcount for writes, 0 for reads. Next state HDR. If read and write are both asserted: err=1 and the command is treated as a write.
- HDR: out_valid=1. Advance one slice per out_valid&out_ready. After HDR_BEATS beats: go DATA for writes; for reads go IDLE (or PAR).
- DATA: emits the buffered word. After its last slice, decrement remaining words. If remaining words is nonzero go FETCH; otherwise go IDLE (or PAR).
- FETCH: out_valid=0. On avs_write, capture avs_writedata and go DATA. avs_read in FETCH sets err=1 and is ignored. Each additional burst word costs at least one bubble cycle.
- out_last=1 on the final beat of the packet: last header beat for reads, last slice of the last word for writes, trailer beat when PAR is used.
- Output stability: out_data and out_last hold stable while out_valid&!out_ready.
- Latency: command accepted in cycle N; first header beat is valid in cycle N+1. Back-to-back packets are allowed: IDLE re-accepts in the cycle after the last beat is accepted.
- burstcount > MAX_BURST: err=1; remaining words is clamped to MAX_BURST; the header carries the clamped value.
- Reset mid-packet aborts immediately. The partial packet is not completed and the next packet starts clean.

Optional Feature:
Macro PKT_PARITY_EN.
- Defined: after the last header/payload beat, the FSM enters PAR and emits one trailer beat equal to the XOR of all prior beats of the packet. out_last moves to the trailer beat; the XOR accumulator clears at IDLE.
- Undefined: no PAR state and no trailer; out_last sits on the last data or header beat.

Test Plan:
1. OUT_W=8, read single, A=0x123456, BE=0011 -> header 0x0C48D158 emitted as 58,D1,48,0C; out_last on 0C; no payload.
2. Write single, A=0, BE=1111, data 0xDEADBEEF -> 01,00,00,3C,EF,BE,AD,DE; out_last on DE.
3. Burst write, A=0x10, burstcount=4, data 1,2,3,4, out_ready=1 -> header 43,00,00,10 then 16 payload beats 01,00,00,00,02,…; avs_waitrequest=1 while each word serialises; burst read, count 8 -> header only, field=8.
4. Scenario 3 with out_ready toggling pseudo-randomly -> identical beat sequence; no loss or duplication; out_data stable during stalls.
5. rst asserted after the 2nd burst word, then scenario 1 -> out_valid=0 and avs_waitrequest=1 immediately during reset; the next packet is clean; burstcount=20 with MAX_BURST=16 -> err=1 and 16 words emitted.
6. PKT_PARITY_EN defined, scenario 1 -> fifth beat CD with out_last=1; err remains 0.
